// File: rtl/led_fade_pwm.sv
// Per-channel PWM LED driver: a high led_in bit loads full brightness, which then
// fades linearly to off in FADE_STEP decrements. Optional macro: LED_FADE_GAMMA_EN.
module led_fade_pwm #(
  parameter int NUM_LEDS    = 16,
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 39062,
  parameter int FADE_STEP   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [NUM_LEDS-1:0] led_in,
  output logic [NUM_LEDS-1:0] LED,
  output logic                active
);

  localparam int SCW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PWM_BITS-1:0] MAXLVL    = '1;
  localparam logic [PWM_BITS-1:0] FSTEP     = PWM_BITS'(FADE_STEP);
  localparam logic [SCW-1:0]      STEP_LAST = SCW'(STEP_CYCLES - 1);

  if (STEP_CYCLES < 1) begin : g_err_step_cycles
    $error("led_fade_pwm: STEP_CYCLES must be >= 1");
  end
  if (FADE_STEP < 1) begin : g_err_fade_step_lo
    $error("led_fade_pwm: FADE_STEP must be >= 1");
  end
  if (FADE_STEP > (2 ** PWM_BITS) - 1) begin : g_err_fade_step_hi
    $error("led_fade_pwm: FADE_STEP must not exceed MAXLVL");
  end
  if (PWM_BITS < 2) begin : g_err_pwm_bits
    $error("led_fade_pwm: PWM_BITS must be >= 2");
  end

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [SCW-1:0]      step_cnt;
  logic                step_tick;
  logic [PWM_BITS-1:0] level     [NUM_LEDS];
  logic [PWM_BITS-1:0] level_nxt [NUM_LEDS];
  logic [PWM_BITS-1:0] duty      [NUM_LEDS];
  logic [NUM_LEDS-1:0] led_nxt;
  logic                active_nxt;

  assign step_tick = (step_cnt == STEP_LAST);

  // Free-running timebases, independent of en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      pwm_cnt  <= pwm_cnt + 1'b1;
      step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
    end
  end

  // Priority: blank, load, saturating fade, hold
  always_comb begin
    active_nxt = 1'b0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      level_nxt[i] = level[i];
      if (!en)
        level_nxt[i] = '0;
      else if (led_in[i])
        level_nxt[i] = MAXLVL;
      else if (step_tick)
        level_nxt[i] = (level[i] >= FSTEP) ? level[i] - FSTEP : '0;
      active_nxt = active_nxt | (level_nxt[i] != '0);
    end
  end

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq [NUM_LEDS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      sq[i]   = {{PWM_BITS{1'b0}}, level[i]} * {{PWM_BITS{1'b0}}, level[i]};
      duty[i] = sq[i][2*PWM_BITS-1:PWM_BITS];
    end
  end
`else
  always_comb begin
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      duty[i] = level[i];
    end
  end
`endif

  // Full level is forced solid on so the top PWM code is not lost
  always_comb begin
    led_nxt = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      led_nxt[i] = en && ((level[i] == MAXLVL) || (duty[i] > pwm_cnt));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        level[i] <= '0;
      end
      LED    <= '0;
      active <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        level[i] <= level_nxt[i];
      end
      LED    <= led_nxt;
      active <= active_nxt;
    end
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Scoreboard bench for led_fade_pwm: two instances (STEP_CYCLES 4 and 64) share
// stimulus; a cycle-level reference model pushes expected outputs for a monitor.
module tb_led_fade_pwm;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       en     = 1'b0;
  logic [3:0] led_in = '0;
  logic [3:0] led_a, led_b;
  logic       act_a, act_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0] expq[$];
  int         lvl[2][4];
  int         k;

  always #5 clk = ~clk;

  led_fade_pwm #(.NUM_LEDS(4), .PWM_BITS(4), .STEP_CYCLES(4), .FADE_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .led_in(led_in), .LED(led_a), .active(act_a)
  );

  led_fade_pwm #(.NUM_LEDS(4), .PWM_BITS(4), .STEP_CYCLES(64), .FADE_STEP(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .en(en), .led_in(led_in), .LED(led_b), .active(act_b)
  );

  task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic int duty(input int l);
`ifdef LED_FADE_GAMMA_EN
    return (l * l) >> 4;
`else
    return l;
`endif
  endfunction

  task automatic model_reset();
    k = 0;
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < 4; i++)
        lvl[n][i] = 0;
  endtask

  // Expected outputs after the coming rising edge; k = edges since reset release
  task automatic model_edge(input bit e, input logic [3:0] li, output logic [9:0] exp);
    int         stepc, pwm;
    bit         tick;
    logic [3:0] ln;
    logic       an;
    logic [4:0] part[2];
    for (int n = 0; n < 2; n++) begin
      stepc = (n == 0) ? 4 : 64;
      tick  = ((k % stepc) == stepc - 1);
      pwm   = k % 16;
      an    = 1'b0;
      ln    = '0;
      for (int i = 0; i < 4; i++) begin
        ln[i] = e && (lvl[n][i] == 15 || duty(lvl[n][i]) > pwm);
        if (!e)         lvl[n][i] = 0;
        else if (li[i]) lvl[n][i] = 15;
        else if (tick)  lvl[n][i] = (lvl[n][i] >= 4) ? lvl[n][i] - 4 : 0;
        if (lvl[n][i] != 0) an = 1'b1;
      end
      part[n] = {ln, an};
    end
    exp = {part[0], part[1]};
    k++;
  endtask

  task automatic step(input bit r, input bit e, input logic [3:0] li);
    logic [9:0] x;
    @(negedge clk);
    rst_n  = r;
    en     = e;
    led_in = li;
    if (!r) begin
      model_reset();
      x = '0;
    end else begin
      model_edge(e, li, x);
    end
    expq.push_back(x);
  endtask

  // Reset pulled low between edges; outputs must clear without a clock edge
  task automatic async_reset();
    @(negedge clk);
    en     = 1'b1;
    led_in = '0;
    #2 rst_n = 1'b0;
    #1 check("async_rst", {led_a, act_a, led_b, act_b}, 10'd0);
    model_reset();
    expq.push_back('0);
  endtask

  initial begin
    logic [9:0] x;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        x = expq.pop_front();
        check("dut_step4", {5'd0, led_a, act_a}, {5'd0, x[9:5]});
        check("dut_step64", {5'd0, led_b, act_b}, {5'd0, x[4:0]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   found;
    int   cnt, exp_cnt, r;
    model_reset();

    // Reset held with active inputs
    repeat (4) step(0, 1, 4'hF);

    // Single-cycle load then full fade with saturation at 0
    step(1, 1, 4'b0001);
    repeat (24) step(1, 1, 4'b0000);

    // Enable blanking and recovery
    repeat (3) step(1, 1, 4'hF);
    repeat (3) step(1, 0, 4'hF);
    repeat (4) step(1, 1, 4'hF);
    repeat (4) step(1, 1, 4'h0);

    // Async reset mid-fade
    step(1, 1, 4'hF);
    step(1, 1, 4'h0);
    async_reset();
    step(0, 1, 4'h0);
    repeat (3) step(1, 1, 4'h0);

    // Collision: reload on the same edge as a tick while level1 = 7
    step(1, 1, 4'b0010);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (lvl[0][1] == 7 && (k % 4) == 3) found = 1'b1;
      else step(1, 1, 4'b0000);
    end
    check("collision_setup", {9'd0, found}, 10'd1);
    step(1, 1, 4'b0010);
    repeat (8) step(1, 1, 4'b0000);

    // Duty on the slow instance while its level0 sits at 7
    step(0, 1, 4'h0);
    step(1, 1, 4'b0001);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (lvl[1][0] == 7) found = 1'b1;
      else step(1, 1, 4'b0000);
    end
    check("duty_setup", {9'd0, found}, 10'd1);
    step(1, 1, 4'b0000);
    cnt = 0;
    repeat (16) begin
      step(1, 1, 4'b0000);
      @(posedge clk);
      #1 cnt += int'(led_b[0]);
    end
`ifdef LED_FADE_GAMMA_EN
    exp_cnt = 3;
`else
    exp_cnt = 7;
`endif
    check("duty_count", 10'(cnt), 10'(exp_cnt));

    // Randomized traffic with occasional async resets
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 99);
      if (r < 2) async_reset();
      else step(1, ($urandom_range(0, 19) != 0),
                ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
    end

    repeat (2) step(1, 1, 4'h0);
    @(posedge clk);
    #2 check("queue_drain", 10'(expq.size()), 10'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
